pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RV32I core; successor to the single-mode PC register.
- Computes next PC from sequential increment, PC-relative branch/JAL, or register-absolute JALR; holds on stall or halt.
- Drives the fetch stage through a valid/ready handshake.
- Sits between the decode/ALU branch-resolution logic and instruction memory.

Parameters:
- XLEN, 32, PC and operand width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset; XLEN bits wide.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero; misaligned if nonzero.

Ports:
- clk, input, 1, system clock, rising edge.
- clr, input, 1, asynchronous active-low reset.
- halt, input, 1, freeze PC and drop fetch_valid while high.
- branch_valid, input, 1, a conditional branch resolves this cycle.
- branch_taken, input, 1, ALU compare result; qualified by branch_valid.
- jump_valid, input, 1, an unconditional jump resolves this cycle.
- jump_abs, input, 1, 1 = JALR target (rs1_val+imm_val, bit0 cleared); 0 = JAL target (pc_val+imm_val).
- rs1_val, input, XLEN, base register for JALR.
- imm_val, input, XLEN, sign-extended immediate.
- fetch_ready, input, 1, instruction memory accepts pc_val this cycle.
- pc_val, output, XLEN, current PC / fetch address.
- pc_plus, output, XLEN, pc_val + INC (link value), combinational.
- fetch_valid, output, 1, pc_val is a valid fetch request.
- misalign_err, output, 1, one-cycle pulse: last accepted redirect target was misaligned.

Behaviour:
- Reset (clr low, asynchronous):
  - pc_val = RESET_VEC, fetch_valid = 0, misalign_err = 0, state = BOOT.
- States:
  - BOOT: fetch_valid = 0 for exactly one cycle after reset release, then go to RUN. The one-cycle gap lets imem come out of reset.
  - RUN: fetch_valid = 1.
  - HALT: fetch_valid = 0; pc_val holds.
- Transitions:
  - RUN→HALT when halt = 1.
  - HALT→RUN when halt = 0.
  - halt = 1 during BOOT goes to HALT when BOOT ends.
- Next-PC priority, registered on clk, evaluated in RUN only:
  1. halt = 1: hold; branch/jump ignored.
  2. jump_valid: target = jump_abs ? ((rs1_val+imm_val) & ~1) : (pc_val+imm_val).
  3. branch_valid & branch_taken: target = pc_val + imm_val.
  4. fetch_ready = 1: pc_val + INC.
  5. Otherwise: hold.
- Redirects (priority 2–3) take effect regardless of fetch_ready. An outstanding unaccepted fetch is cancelled.
- branch_valid & ~branch_taken is a not-taken branch: falls through to rule 4/5; no redirect.
- jump_valid and branch_valid both high: jump wins. This is legal and not an error.
- Arithmetic:
  - All adds are modulo 2^XLEN; wrap-around is silent. Example: PC FFFF_FFFC + 4 = 0000_0000.
  - imm_val is used as-is (already sign-extended).
- Misalignment:
  - If a redirect target has any of the low ALIGN_BITS set (after the JALR bit0 clear), misalign_err pulses high in the cycle after the redirect.
  - Without PC_TRAP_EN the target is still loaded.
- Latency: every PC update is visible on pc_val one clock after the qualifying inputs; pc_plus follows combinationally.
- Handshake: while fetch_valid = 1 and fetch_ready = 0, pc_val is stable unless a redirect or halt occurs.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined: adds parameter TRAP_VEC (default 32'h0000_0100) and output epc [XLEN-1:0] (reset 0). On a misaligned redirect:
  - pc_val loads TRAP_VEC instead of the target.
  - epc captures the offending target.
  - misalign_err pulses as usual.
  - epc otherwise holds.
- Undefined: no epc port; a misaligned target is loaded as-is and only misalign_err is reported.

Test Plan:
- Reset/boot: clr low then released, fetch_ready = 1 → pc_val = 0 with fetch_valid = 0 for 1 cycle; then pc_val = 0, 4, 8 on successive cycles with fetch_valid = 1.
- Stall: pc_val = 8, fetch_ready = 0 for 3 cycles → pc_val holds 8; then fetch_ready = 1 → pc_val = C.
- Branch: pc_val = 10, branch_valid = 1, branch_taken = 1, imm_val = FFFF_FFF0 → pc_val = 0. Same with branch_taken = 0 → pc_val = 14.
- JALR, simultaneous events: pc_val = 20, jump_valid = jump_abs = 1, rs1_val = 103, imm_val = 2, branch_valid = branch_taken = 1 → pc_val = 104, pc_plus was 24, misalign_err = 0 (bit0 cleared, bit1 = 0). rs1_val = 101, imm_val = 1 → target 102 → misalign_err pulses 1 cycle; pc_val = 102 (PC_TRAP_EN off) or 100 with epc = 102 (PC_TRAP_EN on).
- Halt + wrap: pc_val = FFFF_FFFC, halt = 1 with jump_valid = 1 → pc_val holds, fetch_valid = 0. halt = 0, fetch_ready = 1 → pc_val = 0000_0000.
- Async reset mid-run: clr asserted between clock edges at pc_val = 40 → pc_val = RESET_VEC immediately, fetch_valid = 0, BOOT re-entered.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: sequential / PC-relative / register-absolute next PC with a
// one-cycle boot gap and valid/ready fetch handshake. Define PC_TRAP_EN to redirect misaligned targets to TRAP_VEC.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h0000_0000),
  parameter int              INC        = 4,
  parameter int              ALIGN_BITS = 2
`ifdef PC_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100)
`endif
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            halt,
  input  logic            branch_valid,
  input  logic            branch_taken,
  input  logic            jump_valid,
  input  logic            jump_abs,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] imm_val,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_val,
  output logic [XLEN-1:0] pc_plus,
  output logic            fetch_valid,
  output logic            misalign_err
`ifdef PC_TRAP_EN
  ,
  output logic [XLEN-1:0] epc
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] rel_sum;
  logic [XLEN-1:0] abs_sum;
  logic            redirect;
  logic            misalign;

  assign pc_plus     = pc_val + XLEN'(INC);
  assign rel_sum     = pc_val + imm_val;
  assign abs_sum     = rs1_val + imm_val;
  assign fetch_valid = (state == RUN);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_val;
    redirect  = 1'b0;
    target    = rel_sum;
    case (state)
      BOOT: state_nxt = halt ? HALT : RUN;
      RUN: begin
        if (halt) begin
          state_nxt = HALT;
        end else if (jump_valid) begin
          redirect = 1'b1;
          target   = jump_abs ? {abs_sum[XLEN-1:1], 1'b0} : rel_sum;
        end else if (branch_valid && branch_taken) begin
          redirect = 1'b1;
        end else if (fetch_ready) begin
          pc_nxt = pc_plus;
        end
      end
      HALT: if (!halt) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase

    misalign = redirect && ((target & ALIGN_MASK) != '0);
    if (redirect) begin
`ifdef PC_TRAP_EN
      pc_nxt = misalign ? TRAP_VEC : target;
`else
      pc_nxt = target;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= BOOT;
      pc_val       <= RESET_VEC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_val       <= pc_nxt;
      misalign_err <= misalign;
    end
  end

`ifdef PC_TRAP_EN
  // The offending target is kept until the next misaligned redirect.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      epc <= '0;
    end else if (misalign) begin
      epc <= target;
    end
  end
`endif

endmodule
